// File: rtl/pipeline_pkg.sv
// ============================================================================
// Package     : pipeline_pkg
// Description : Opcode constants, ALUControl / ImmSrc / ResultSrc / Forward
//               encodings, the decoded control bundle, and hazard/forward helpers
//               shared by the five-stage pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  // Opcodes (InstrD[6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format selects
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Writeback result selects
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Operand forwarding selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Decode-stage control bundle
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
    logic [1:0] imm_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Forward select for one source operand; the younger (M) producer wins, x0 never forwards.
  function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                            input logic [4:0] rd_m, input logic we_m,
                                            input logic [4:0] rd_w, input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return FWD_M;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  // True when a decode-stage source is still being produced by any in-flight writer.
  function automatic logic reg_hazard(input logic [4:0] rs,
                                      input logic [4:0] rd_e, input logic we_e,
                                      input logic [4:0] rd_m, input logic we_m,
                                      input logic [4:0] rd_w, input logic we_w);
    return (rs != 5'd0) &&
           ((we_e && (rd_e == rs)) || (we_m && (rd_m == rs)) || (we_w && (rd_w == rs)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_controller_control_decoder.sv
// ============================================================================
// Module      : control_decoder
// Description : Purely combinational Decode-stage control decoder. Unknown
//               opcodes produce an all-zero control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_decoder
  import pipeline_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output ctrl_t      ctrl
);

  logic [2:0] alu_fn;

  // ALU operation for R-type / I-ALU; subtraction only for R-type funct3=000 with funct7 set
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = ((op == OP_RTYPE) && funct7) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // Opcode to control mapping; anything unrecognised stays a bubble
  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.imm_src    = IMM_I;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
      end
      OP_RTYPE: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_fn;
      end
      OP_IALU: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.imm_src     = IMM_I;
        ctrl.alu_control = alu_fn;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.imm_src     = IMM_B;
        ctrl.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_controller.sv
// ============================================================================
// Module      : pipeline_controller
// Description : Five-stage pipeline control: decode, D->E->M->W control
//               registers, branch/jump redirect, load-use / RAW hazard stalls
//               and operand forwarding selects.
//               Macro PIPELINE_FORWARDING_EN: defined -> M/W forwarding with
//               load-use stalls only; undefined -> no forwarding, stall on
//               any in-flight producer until it retires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_controller
  import pipeline_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       ZeroE,
  output logic [1:0] ImmSrcD,
  output logic       ALUSrcE,
  output logic [2:0] ALUControlE,
  output logic       PCSrcE,
  output logic       MemWriteM,
  output logic       RegWriteW,
  output logic [1:0] ResultSrcW,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  ctrl_t ctrl_d;

  // Execute-stage registers
  logic       reg_write_e;
  logic [1:0] result_src_e;
  logic       mem_write_e;
  logic       jump_e;
  logic       branch_e;
  logic [2:0] alu_control_e;
  logic       alu_src_e;
  logic [4:0] rs1_e;
  logic [4:0] rs2_e;
  logic [4:0] rd_e;

  // Memory-stage registers
  logic       reg_write_m;
  logic [1:0] result_src_m;
  logic       mem_write_m;
  logic [4:0] rd_m;

  // Writeback-stage registers
  logic       reg_write_w;
  logic [1:0] result_src_w;
  logic [4:0] rd_w;

  logic       stall_req;
  logic       redirect;

  control_decoder u_decoder (
    .op     (OP),
    .funct3 (funct3),
    .funct7 (funct7),
    .ctrl   (ctrl_d)
  );

  // D->E register; a flush or reset loads a bubble so nothing younger can commit
  always_ff @(posedge CLK) begin
    if (RESET || FlushE) begin
      reg_write_e   <= 1'b0;
      result_src_e  <= RES_ALU;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_control_e <= ALU_ADD;
      alu_src_e     <= 1'b0;
      rs1_e         <= 5'd0;
      rs2_e         <= 5'd0;
      rd_e          <= 5'd0;
    end else begin
      reg_write_e   <= ctrl_d.reg_write;
      result_src_e  <= ctrl_d.result_src;
      mem_write_e   <= ctrl_d.mem_write;
      jump_e        <= ctrl_d.jump;
      branch_e      <= ctrl_d.branch;
      alu_control_e <= ctrl_d.alu_control;
      alu_src_e     <= ctrl_d.alu_src;
      rs1_e         <= Rs1D;
      rs2_e         <= Rs2D;
      rd_e          <= RdD;
    end
  end

  // E->M and M->W registers advance every cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      reg_write_m  <= 1'b0;
      result_src_m <= RES_ALU;
      mem_write_m  <= 1'b0;
      rd_m         <= 5'd0;
      reg_write_w  <= 1'b0;
      result_src_w <= RES_ALU;
      rd_w         <= 5'd0;
    end else begin
      reg_write_m  <= reg_write_e;
      result_src_m <= result_src_e;
      mem_write_m  <= mem_write_e;
      rd_m         <= rd_e;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
    end
  end

`ifdef PIPELINE_FORWARDING_EN
  // Load-use: the loaded value is not available to forward until W
  always_comb begin
    stall_req = (result_src_e == RES_MEM) && (rd_e != 5'd0) &&
                ((rd_e == Rs1D) || (rd_e == Rs2D));
    ForwardAE = fwd_select(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    ForwardBE = fwd_select(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  end
`else
  // Source registers in E only matter for forwarding, which this build lacks
  logic unused_rs_e;
  assign unused_rs_e = ^{rs1_e, rs2_e};

  // Without forwarding, hold D until every pending writer of a source has retired
  always_comb begin
    stall_req = reg_hazard(Rs1D, rd_e, reg_write_e, rd_m, reg_write_m, rd_w, reg_write_w) ||
                reg_hazard(Rs2D, rd_e, reg_write_e, rd_m, reg_write_m, rd_w, reg_write_w);
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
  end
`endif

  // Redirect resolution and hazard outputs; a taken redirect overrides any stall
  always_comb begin
    redirect = (branch_e & ZeroE) | jump_e;
    PCSrcE   = redirect;
    StallF   = stall_req & ~redirect;
    StallD   = stall_req & ~redirect;
    FlushD   = redirect;
    FlushE   = stall_req | redirect;
  end

  assign ImmSrcD     = ctrl_d.imm_src;
  assign ALUSrcE     = alu_src_e;
  assign ALUControlE = alu_control_e;
  assign MemWriteM   = mem_write_m;
  assign RegWriteW   = reg_write_w;
  assign ResultSrcW  = result_src_w;

endmodule

`default_nettype wire
